uart_rx: RTL and testbench

//  Asynchronous serial receiver (8N1 default) that consumes the 16x oversampling tick of the

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_synchronizer.sv | 24 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, defaults and
// the 2-of-3 sample vote.
package uart_pkg;

    localparam int unsigned DBIT_DEFAULT       = 8;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// idle-high serial line does not produce a false edge on reset release.
module rx_synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-edge detect with generator phase reset,
// 2-of-3 voted data/stop sampling, valid/ready output register with flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = DBIT_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned SAMPLE_MID = OVERSAMPLE / 2 - 1
) (
    input  logic            clk_50MHz,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            tick,
    output logic            phase_reset,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            framing_err,
    output logic            overrun_err
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned NW = $clog2(DBIT + 1);

    localparam logic [SW-1:0] S_EARLY = SW'(SAMPLE_MID - 1);
    localparam logic [SW-1:0] S_MID   = SW'(SAMPLE_MID);
    localparam logic [SW-1:0] S_LATE  = SW'(SAMPLE_MID + 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    rx_state_t       state;
    logic            rxs;
    logic            prev;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;
    logic [2:0]      votes;
    logic            data_bit;
    logic            stop_bit;

    rx_synchronizer #(.WIDTH(1)) u_sync (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .d         (rx),
        .q         (rxs)
    );

    assign data_bit = majority3(votes[0], votes[1], votes[2]);
    assign stop_bit = majority3(votes[0], votes[1], rxs);

    // s keeps its origin at each bit's leading edge (START runs the full bit
    // after validating at its centre), so the three votes straddle bit centres.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state       <= IDLE;
            prev        <= 1'b1;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            votes       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            phase_reset <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            prev        <= rxs;
            phase_reset <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (prev && !rxs) begin
                        phase_reset <= 1'b1;
                        s           <= '0;
                        state       <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID && rxs) begin
                            state <= IDLE;
                        end else if (s == S_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_EARLY) votes[0] <= rxs;
                        if (s == S_MID)   votes[1] <= rxs;
                        if (s == S_LATE)  votes[2] <= rxs;
                        if (s == S_LAST) begin
                            shreg <= {data_bit, shreg[DBIT-1:1]};
                            s     <= '0;
                            n     <= n + 1'b1;
                            if (n == N_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_EARLY) votes[0] <= rxs;
                        if (s == S_MID)   votes[1] <= rxs;
                        if (s == S_LATE) begin
                            state <= IDLE;
                            if (stop_bit) begin
                                rx_data     <= shreg;
                                rx_valid    <= 1'b1;
                                overrun_err <= rx_valid && !rx_ready;
                            end else begin
                                framing_err <= 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: M=4 tick generator, directed frames, and a scoreboard of
// expected frame outcomes checked against the output register every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam realtime CLK_HALF = 10.0;
    localparam realtime BIT_NS   = 1280.0;

    typedef struct {
        logic        frame_err;
        logic [7:0]  data;
        int unsigned deadline;
    } exp_t;

    logic       clk_50MHz = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       tick;
    logic       phase_reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun_err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned fall_cyc, pr_cycle;
    int unsigned pr_count = 0, fe_count = 0, ov_count = 0, byte_count = 0;
    logic [7:0]  last_byte = '0;
    exp_t        exp_q[$];
    logic [1:0]  gen_cnt;

    uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SAMPLE_MID(7)) dut (
        .clk_50MHz   (clk_50MHz),
        .reset_n     (reset_n),
        .rx          (rx),
        .tick        (tick),
        .phase_reset (phase_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #(CLK_HALF) clk_50MHz = ~clk_50MHz;

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n || phase_reset || gen_cnt == 2'd3) gen_cnt <= '0;
        else gen_cnt <= gen_cnt + 2'd1;
    end
    assign tick = (gen_cnt == 2'd3) && !phase_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk_50MHz) begin
        logic       p_valid, p_ready, p_rst, done;
        logic [7:0] p_data;
        exp_t       e;
        p_valid = rx_valid;
        p_ready = rx_ready;
        p_rst   = reset_n;
        p_data  = rx_data;
        #1;
        cyc++;
        if (phase_reset) begin
            pr_count++;
            pr_cycle = cyc;
        end
        if (!p_rst) begin
            chk("rst_valid", 32'(rx_valid), 32'd0);
            chk("rst_data", 32'(rx_data), 32'd0);
            chk("rst_flags", {29'd0, phase_reset, framing_err, overrun_err}, 32'd0);
        end else begin
            done = rx_valid && (!p_valid || p_ready || overrun_err);
            if (framing_err) begin
                fe_count++;
                if (exp_q.size() == 0) chk("unexpected_framing", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("framing_kind", 32'(e.frame_err), 32'd1);
                end
            end
            if (done) begin
                byte_count++;
                last_byte = rx_data;
                if (exp_q.size() == 0) chk("unexpected_byte", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("byte_kind", 32'(e.frame_err), 32'd0);
                    chk("byte_data", 32'(rx_data), 32'(e.data));
                    chk("overrun_flag", 32'(overrun_err), 32'(p_valid && !p_ready));
                end
            end else begin
                chk("valid_hold", 32'(rx_valid), 32'(p_valid && !p_ready));
                if (rx_valid) chk("data_stable", 32'(rx_data), 32'(p_data));
                chk("no_overrun", 32'(overrun_err), 32'd0);
            end
            if (overrun_err) ov_count++;
            if (exp_q.size() > 0 && cyc > exp_q[0].deadline) begin
                chk("frame_timeout", 32'd1, 32'd0);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input realtime bit_t,
                              input logic stop_v, input int glitch_bit);
        exp_t e;
        repeat (16) @(negedge clk_50MHz);
        #3;
        fall_cyc    = cyc;
        e.frame_err = !stop_v;
        e.data      = b;
        e.deadline  = cyc + 32'($rtoi(bit_t * 11.0 / 20.0)) + 40;
        exp_q.push_back(e);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                // 3-clk inversion placed over the centre vote only
                #(bit_t / 2 + 20.0);
                rx = !b[i];
                #60;
                rx = b[i];
                #(bit_t / 2 - 80.0);
            end else begin
                #(bit_t);
            end
        end
        rx = stop_v;
        #(bit_t);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pr0, fe0, ov0, bc0;
        logic [7:0]  b5a;
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk_50MHz);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_50MHz);
        chk("idle_state", 32'(dut.state), 32'(IDLE));

        pr0 = pr_count;
        send_frame(8'h55, BIT_NS, 1'b1, -1);
        repeat (40) @(negedge clk_50MHz);
        chk("pr_pulses_55", pr_count - pr0, 32'd1);
        chk("pr_latency_55", pr_cycle - fall_cyc, 32'd3);
        chk("byte_55", 32'(last_byte), 32'h55);

        bc0 = byte_count;
        fe0 = fe_count;
        rx  = 1'b0;
        repeat (20) @(negedge clk_50MHz);
        rx = 1'b1;
        repeat (128) @(negedge clk_50MHz);
        chk("glitch_no_byte", byte_count - bc0, 32'd0);
        chk("glitch_no_fe", fe_count - fe0, 32'd0);
        chk("glitch_idle", 32'(dut.state), 32'(IDLE));

        bc0 = byte_count;
        fe0 = fe_count;
        send_frame(8'hA3, BIT_NS, 1'b0, -1);
        repeat (640) @(negedge clk_50MHz);
        rx = 1'b1;
        repeat (200) @(negedge clk_50MHz);
        chk("break_fe_once", fe_count - fe0, 32'd1);
        chk("break_no_byte", byte_count - bc0, 32'd0);
        chk("break_valid", 32'(rx_valid), 32'd0);

        ov0      = ov_count;
        rx_ready = 1'b0;
        send_frame(8'h11, BIT_NS, 1'b1, -1);
        send_frame(8'h22, BIT_NS, 1'b1, -1);
        repeat (40) @(negedge clk_50MHz);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h22);
        chk("ovr_pulses", ov_count - ov0, 32'd1);
        rx_ready = 1'b1;
        @(negedge clk_50MHz);
        rx_ready = 1'b0;
        chk("accept_clears", 32'(rx_valid), 32'd0);
        repeat (4) @(negedge clk_50MHz);
        rx_ready = 1'b1;

        send_frame(8'hC3, BIT_NS * 1.035, 1'b1, -1);
        repeat (40) @(negedge clk_50MHz);
        chk("byte_slow_c3", 32'(last_byte), 32'hC3);
        last_byte = '0;
        send_frame(8'hC3, BIT_NS * 0.965, 1'b1, -1);
        repeat (40) @(negedge clk_50MHz);
        chk("byte_fast_c3", 32'(last_byte), 32'hC3);
        last_byte = '0;
        send_frame(8'hC3, BIT_NS, 1'b1, 4);
        repeat (40) @(negedge clk_50MHz);
        chk("byte_noise_c3", 32'(last_byte), 32'hC3);

        b5a = 8'h5A;
        bc0 = byte_count;
        repeat (16) @(negedge clk_50MHz);
        #3;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = b5a[i];
            #(BIT_NS);
        end
        rx = b5a[3];
        #(BIT_NS / 2);
        @(negedge clk_50MHz);
        chk("pre_reset_data_state", 32'(dut.state), 32'(DATA));
        reset_n = 1'b0;
        @(negedge clk_50MHz);
        chk("reset_idle", 32'(dut.state), 32'(IDLE));
        chk("reset_valid", 32'(rx_valid), 32'd0);
        reset_n = 1'b1;
        rx      = 1'b1;
        repeat (128) @(negedge clk_50MHz);
        chk("reset_no_byte", byte_count - bc0, 32'd0);
        send_frame(8'h7E, BIT_NS, 1'b1, -1);
        repeat (40) @(negedge clk_50MHz);
        chk("byte_7e", 32'(last_byte), 32'h7E);

        repeat (100) @(negedge clk_50MHz);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
